// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped once per clock, LSB first, registered carry.
// Optional subtract mode is compiled in with `define SERIAL_ADDER_SUB_EN.

module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  logic xy_s;

  assign xy_s = x ^ y;
  assign s    = xy_s ^ z;
  assign c    = (x & y) | (z & xy_s);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum_s;
  logic             fa_carry_s;

  full_adder_cell u_cell (
    .x (a_q[0]),
    .y (b_q[0]),
    .z (carry_q),
    .s (fa_sum_s),
    .c (fa_carry_s)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = a;
          cnt_d   = {CW{1'b0}};
`ifdef SERIAL_ADDER_SUB_EN
          // Two's-complement subtract: invert B and force carry-in to one
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_carry_s;
        sum_d   = {fa_sum_s, sum_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          cout_d  = fa_carry_s;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): vector table plus multi-cycle corner sequences.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Issue one start, scramble operands after acceptance, wait for done (bounded).
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        output logic [W-1:0] rs, output logic rc, output int lat, output int nbusy);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
    lat = -1; nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    rs = sum; rc = cout;
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    int           nbusy;
    int           cyc;
    int           ndone;
    int           dcyc[3];

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, rs, rc, lat, nbusy);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(W));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(nbusy), 64'(W));
      chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].es));
      chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].ec));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_single", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d_sum_hold", i), 64'({cout, sum}), 64'({vecs[i].ec, vecs[i].es}));
    end

    // start during SHIFT must be ignored and not queued
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("ignore_done_seen", 64'(lat >= 0), 64'd1);
    chk("ignore_sum", 64'(sum), 64'h10);
    chk("ignore_cout", 64'(cout), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("ignore_no_requeue", 64'({busy, done}), 64'd0);

    // Reset during the 4th SHIFT cycle discards the operation
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    run_op(8'h12, 8'h34, 1'b0, rs, rc, lat, nbusy);
    chk("postrst_latency", 64'(lat), 64'(W));
    chk("postrst_sum", 64'(rs), 64'h46);
    chk("postrst_cout", 64'(rc), 64'd0);

    // start held high: one result every WIDTH+2 cycles
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    ndone = 0; cyc = 0;
    for (int k = 0; k < 60 && ndone < 3; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        dcyc[ndone] = cyc;
        ndone++;
        chk($sformatf("b2b_sum%0d", ndone), 64'(sum), 64'h02);
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 64'(ndone), 64'd3);
    if (ndone == 3) begin
      chk("b2b_period1", 64'(dcyc[1] - dcyc[0]), 64'(W + 2));
      chk("b2b_period2", 64'(dcyc[2] - dcyc[1]), 64'(W + 2));
    end
    repeat (3) @(posedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, rs, rc, lat, nbusy);
    chk("sub_10_01_sum", 64'(rs), 64'h0F);
    chk("sub_10_01_cout", 64'(rc), 64'd1);
    run_op(8'h00, 8'h01, 1'b0, rs, rc, lat, nbusy);
    chk("sub_00_01_sum", 64'(rs), 64'hFF);
    chk("sub_00_01_cout", 64'(rc), 64'd0);
    sub = 1'b0;
    run_op(8'h10, 8'h01, 1'b1, rs, rc, lat, nbusy);
    chk("sub0_add_sum", 64'(rs), 64'h12);
    chk("sub0_add_cout", 64'(rc), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
